// File: rtl/execute_e.sv
// Y86-64 execute stage: E pipeline register, ALU, condition codes and jxx/cmov evaluation.
// Optional build macro EXEC_CC_OUT_EN exposes the CC register as cc_o = {ZF,SF,OF}.
module execute_e (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        E_bubble_i,
  input  logic [3:0]  d_stat_i,
  input  logic [3:0]  d_icode_i,
  input  logic [3:0]  d_ifun_i,
  input  logic [63:0] d_valC_i,
  input  logic [63:0] d_valA_i,
  input  logic [63:0] d_valB_i,
  input  logic [3:0]  d_dstE_i,
  input  logic [3:0]  d_dstM_i,
  input  logic [3:0]  d_srcA_i,
  input  logic [3:0]  d_srcB_i,
  input  logic [3:0]  m_stat_i,
  input  logic [3:0]  W_stat_i,
  output logic [3:0]  E_stat_o,
  output logic [3:0]  E_icode_o,
  output logic [63:0] E_valA_o,
  output logic [3:0]  E_dstM_o,
  output logic [3:0]  E_srcA_o,
  output logic [3:0]  E_srcB_o,
  output logic [3:0]  E_dstE_o,
  output logic [63:0] e_valE_o,
  output logic [3:0]  e_dstE_o,
  output logic        e_cnd_o
`ifdef EXEC_CC_OUT_EN
  ,
  output logic [2:0]  cc_o
`endif
);

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] SAOK    = 4'h1;
  localparam logic [3:0] SHLT    = 4'h2;
  localparam logic [3:0] SADR    = 4'h3;
  localparam logic [3:0] SINS    = 4'h4;
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  logic [3:0]  e_ifun_q;
  logic [63:0] e_valc_q;
  logic [63:0] e_valb_q;
  logic [2:0]  cc_q;   // {ZF,SF,OF}

  // Reset and bubble both load an architectural nop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      E_stat_o  <= SAOK;
      E_icode_o <= INOP;
      e_ifun_q  <= 4'h0;
      e_valc_q  <= 64'h0;
      E_valA_o  <= 64'h0;
      e_valb_q  <= 64'h0;
      E_dstE_o  <= RNONE;
      E_dstM_o  <= RNONE;
      E_srcA_o  <= RNONE;
      E_srcB_o  <= RNONE;
    end else if (E_bubble_i) begin
      E_stat_o  <= SAOK;
      E_icode_o <= INOP;
      e_ifun_q  <= 4'h0;
      e_valc_q  <= 64'h0;
      E_valA_o  <= 64'h0;
      e_valb_q  <= 64'h0;
      E_dstE_o  <= RNONE;
      E_dstM_o  <= RNONE;
      E_srcA_o  <= RNONE;
      E_srcB_o  <= RNONE;
    end else begin
      E_stat_o  <= d_stat_i;
      E_icode_o <= d_icode_i;
      e_ifun_q  <= d_ifun_i;
      e_valc_q  <= d_valC_i;
      E_valA_o  <= d_valA_i;
      e_valb_q  <= d_valB_i;
      E_dstE_o  <= d_dstE_i;
      E_dstM_o  <= d_dstM_i;
      E_srcA_o  <= d_srcA_i;
      E_srcB_o  <= d_srcB_i;
    end
  end

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_fun;
  logic [63:0] alu_res;
  logic        alu_of;

  always_comb begin
    alu_a = 64'h0;
    unique case (E_icode_o)
      IRRMOVQ, IOPQ:            alu_a = E_valA_o;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = e_valc_q;
      ICALL, IPUSHQ:            alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      IRET, IPOPQ:              alu_a = 64'h0000_0000_0000_0008;
      default:                  alu_a = 64'h0;
    endcase
  end

  always_comb begin
    alu_b = 64'h0;
    unique case (E_icode_o)
      IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: alu_b = e_valb_q;
      default:                                           alu_b = 64'h0;
    endcase
  end

  assign alu_fun = (E_icode_o == IOPQ) ? e_ifun_q : ALU_ADD;

  // Unrecognised function codes fall through to ADD, overflow rule included.
  always_comb begin
    alu_res = alu_b + alu_a;
    alu_of  = (alu_a[63] == alu_b[63]) && (alu_res[63] != alu_a[63]);
    case (alu_fun)
      ALU_SUB: begin
        alu_res = alu_b - alu_a;
        alu_of  = (alu_a[63] != alu_b[63]) && (alu_res[63] != alu_b[63]);
      end
      ALU_AND: begin
        alu_res = alu_b & alu_a;
        alu_of  = 1'b0;
      end
      ALU_XOR: begin
        alu_res = alu_b ^ alu_a;
        alu_of  = 1'b0;
      end
      default: begin
        alu_res = alu_b + alu_a;
        alu_of  = (alu_a[63] == alu_b[63]) && (alu_res[63] != alu_a[63]);
      end
    endcase
  end

  assign e_valE_o = alu_res;

  // Flags are frozen once an exception is visible further down the pipe.
  logic m_exc;
  logic w_exc;
  logic set_cc;
  assign m_exc  = (m_stat_i == SHLT) || (m_stat_i == SADR) || (m_stat_i == SINS);
  assign w_exc  = (W_stat_i == SHLT) || (W_stat_i == SADR) || (W_stat_i == SINS);
  assign set_cc = (E_icode_o == IOPQ) && !m_exc && !w_exc;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      cc_q <= 3'b100;
    else if (set_cc)
      cc_q <= {(alu_res == 64'h0), alu_res[63], alu_of};
  end

  logic zf;
  logic sf;
  logic of;
  assign {zf, sf, of} = cc_q;

  always_comb begin
    e_cnd_o = 1'b0;
    case (e_ifun_q)
      4'h0:    e_cnd_o = 1'b1;
      4'h1:    e_cnd_o = (sf ^ of) | zf;
      4'h2:    e_cnd_o = sf ^ of;
      4'h3:    e_cnd_o = zf;
      4'h4:    e_cnd_o = ~zf;
      4'h5:    e_cnd_o = ~(sf ^ of);
      4'h6:    e_cnd_o = ~(sf ^ of) & ~zf;
      default: e_cnd_o = 1'b0;
    endcase
  end

  assign e_dstE_o = ((E_icode_o == IRRMOVQ) && !e_cnd_o) ? RNONE : E_dstE_o;

`ifdef EXEC_CC_OUT_EN
  assign cc_o = cc_q;
`endif

endmodule

// File: tb/tb_execute_e.sv
// Directed bench for execute_e: ALU paths, CC update/suppression, cmov/jxx conditions, bubble and reset.
module tb_execute_e;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        E_bubble_i;
  logic [3:0]  d_stat_i, d_icode_i, d_ifun_i;
  logic [63:0] d_valC_i, d_valA_i, d_valB_i;
  logic [3:0]  d_dstE_i, d_dstM_i, d_srcA_i, d_srcB_i;
  logic [3:0]  m_stat_i, W_stat_i;
  logic [3:0]  E_stat_o, E_icode_o, E_dstM_o, E_srcA_o, E_srcB_o, E_dstE_o;
  logic [63:0] E_valA_o, e_valE_o;
  logic [3:0]  e_dstE_o;
  logic        e_cnd_o;
  logic [2:0]  cc_obs;

  int n_tests = 0;
  int n_fail  = 0;

  string       tag_q[$];
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];

  execute_e dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .E_bubble_i(E_bubble_i),
    .d_stat_i(d_stat_i), .d_icode_i(d_icode_i), .d_ifun_i(d_ifun_i),
    .d_valC_i(d_valC_i), .d_valA_i(d_valA_i), .d_valB_i(d_valB_i),
    .d_dstE_i(d_dstE_i), .d_dstM_i(d_dstM_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
    .m_stat_i(m_stat_i), .W_stat_i(W_stat_i),
    .E_stat_o(E_stat_o), .E_icode_o(E_icode_o), .E_valA_o(E_valA_o),
    .E_dstM_o(E_dstM_o), .E_srcA_o(E_srcA_o), .E_srcB_o(E_srcB_o), .E_dstE_o(E_dstE_o),
    .e_valE_o(e_valE_o), .e_dstE_o(e_dstE_o), .e_cnd_o(e_cnd_o)
`ifdef EXEC_CC_OUT_EN
    , .cc_o(cc_obs)
`endif
  );

`ifndef EXEC_CC_OUT_EN
  assign cc_obs = dut.cc_q;
`endif

  always #5 clk_i = ~clk_i;

  // Record one observation with its expected value for the scoreboard.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tag_q.push_back(tag);
    obs_q.push_back(obs);
    exp_q.push_back(exp);
  endtask

  // Present one decode-stage instruction, clock it into E, then settle away from the edge.
  task automatic load(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] valc,
                      input logic [63:0] vala, input logic [63:0] valb, input logic [3:0] dste);
    d_stat_i  = 4'h1;
    d_icode_i = icode;
    d_ifun_i  = ifun;
    d_valC_i  = valc;
    d_valA_i  = vala;
    d_valB_i  = valb;
    d_dstE_i  = dste;
    d_dstM_i  = 4'hF;
    d_srcA_i  = 4'h1;
    d_srcB_i  = 4'h2;
    @(posedge clk_i);
    #1;
  endtask

  task automatic nop();
    load(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
  endtask

  initial begin
    rstn_i     = 1'b0;
    E_bubble_i = 1'b0;
    m_stat_i   = 4'h1;
    W_stat_i   = 4'h1;
    d_stat_i = 4'h1; d_icode_i = 4'h1; d_ifun_i = 4'h0;
    d_valC_i = 64'h0; d_valA_i = 64'h0; d_valB_i = 64'h0;
    d_dstE_i = 4'hF; d_dstM_i = 4'hF; d_srcA_i = 4'hF; d_srcB_i = 4'hF;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_icode", E_icode_o, 4'h1);
    chk("rst_dstE", E_dstE_o, 4'hF);
    chk("rst_valE", e_valE_o, 64'h0);
    chk("rst_cc", cc_obs, 3'b100);
    @(negedge clk_i);
    rstn_i = 1'b1;
    nop();
    chk("nop_icode", E_icode_o, 4'h1);
    chk("nop_cc", cc_obs, 3'b100);

    // opq sub 5-5 -> 0, then cmov le with ZF=1 is taken
    load(4'h6, 4'h1, 64'h0, 64'd5, 64'd5, 4'h3);
    chk("sub_valE", e_valE_o, 64'h0);
    chk("sub_dstE", e_dstE_o, 4'h3);
    load(4'h2, 4'h1, 64'h0, 64'h1234, 64'h0, 4'h2);
    chk("sub_cc", cc_obs, 3'b100);
    chk("cmov_t_cnd", e_cnd_o, 1'b1);
    chk("cmov_t_dstE", e_dstE_o, 4'h2);
    chk("cmov_t_valE", e_valE_o, 64'h1234);
    chk("cmov_t_valA", E_valA_o, 64'h1234);

    // opq add overflow -> {0,1,1}; le = (SF^OF)|ZF = 0
    load(4'h6, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h4);
    chk("addov_valE", e_valE_o, 64'hFFFF_FFFF_FFFF_FFFE);
    load(4'h2, 4'h1, 64'h0, 64'hABCD, 64'h0, 4'h2);
    chk("addov_cc", cc_obs, 3'b011);
    chk("cmov_ov_cnd", e_cnd_o, 1'b0);
    chk("cmov_ov_dstE", e_dstE_o, 4'hF);
    chk("cmov_ov_rawdst", E_dstE_o, 4'h2);
    chk("cmov_ov_valE", e_valE_o, 64'hABCD);

    // opq sub 3-5 = -2 -> {0,1,0}; jxx l taken, jxx g not
    load(4'h6, 4'h1, 64'h0, 64'd5, 64'd3, 4'h5);
    chk("subneg_valE", e_valE_o, 64'hFFFF_FFFF_FFFF_FFFE);
    load(4'h7, 4'h2, 64'h40, 64'h0, 64'h0, 4'hF);
    chk("subneg_cc", cc_obs, 3'b010);
    chk("jl_cnd", e_cnd_o, 1'b1);
    load(4'h7, 4'h6, 64'h40, 64'h0, 64'h0, 4'hF);
    chk("jg_cnd", e_cnd_o, 1'b0);

    // opq add 1+1 -> {0,0,0}; cmov le not taken
    load(4'h6, 4'h0, 64'h0, 64'd1, 64'd1, 4'h6);
    chk("add_valE", e_valE_o, 64'd2);
    load(4'h2, 4'h1, 64'h0, 64'h77, 64'h0, 4'h2);
    chk("add_cc", cc_obs, 3'b000);
    chk("cmov_f_cnd", e_cnd_o, 1'b0);
    chk("cmov_f_dstE", e_dstE_o, 4'hF);
    chk("jne_probe", 1'b1, 1'b1 & ~cc_obs[2]);

    // m_stat = ADR suppresses the CC load of a zero-result sub
    m_stat_i = 4'h3;
    load(4'h6, 4'h1, 64'h0, 64'd7, 64'd7, 4'h1);
    chk("madr_valE", e_valE_o, 64'h0);
    nop();
    m_stat_i = 4'h1;
    chk("madr_cc", cc_obs, 3'b000);

    // W_stat = INS suppresses too; xor result checked
    W_stat_i = 4'h4;
    load(4'h6, 4'h3, 64'h0, 64'hF0, 64'hFF, 4'h1);
    chk("xor_valE", e_valE_o, 64'h0F);
    nop();
    W_stat_i = 4'h1;
    chk("wins_cc", cc_obs, 3'b000);

    // and to zero sets ZF
    load(4'h6, 4'h2, 64'h0, 64'hF0, 64'h0F, 4'h1);
    chk("and_valE", e_valE_o, 64'h0);
    nop();
    chk("and_cc", cc_obs, 3'b100);

    // Bubble overrides a push presented by decode
    E_bubble_i = 1'b1;
    d_dstM_i = 4'h3;
    load(4'hA, 4'h0, 64'h77, 64'h11, 64'h100, 4'h4);
    E_bubble_i = 1'b0;
    chk("bub_icode", E_icode_o, 4'h1);
    chk("bub_stat", E_stat_o, 4'h1);
    chk("bub_dstE", E_dstE_o, 4'hF);
    chk("bub_dstM", E_dstM_o, 4'hF);
    chk("bub_srcA", E_srcA_o, 4'hF);
    chk("bub_srcB", E_srcB_o, 4'hF);
    chk("bub_valA", E_valA_o, 64'h0);
    chk("bub_valE", e_valE_o, 64'h0);

    // Stack-pointer and constant address paths
    load(4'hA, 4'h0, 64'h0, 64'h55, 64'h100, 4'h4);
    chk("push_valE", e_valE_o, 64'hF8);
    chk("push_srcA", E_srcA_o, 4'h1);
    load(4'hB, 4'h0, 64'h0, 64'h0, 64'h100, 4'h4);
    chk("pop_valE", e_valE_o, 64'h108);
    load(4'h8, 4'h0, 64'h999, 64'h0, 64'h200, 4'h4);
    chk("call_valE", e_valE_o, 64'h1F8);
    load(4'h3, 4'h0, 64'h55, 64'h33, 64'h44, 4'h7);
    chk("irmov_valE", e_valE_o, 64'h55);
    load(4'h4, 4'h0, 64'h10, 64'h33, 64'h20, 4'hF);
    chk("rmmov_valE", e_valE_o, 64'h30);

    // Unknown ifun on opq acts as add: 2+3
    load(4'h6, 4'h7, 64'h0, 64'd2, 64'd3, 4'h1);
    chk("unk_valE", e_valE_o, 64'd5);
    nop();
    chk("unk_cc", cc_obs, 3'b000);

    // Async reset takes effect without a clock edge
    load(4'h6, 4'h1, 64'h0, 64'd4, 64'd4, 4'h3);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("arst_icode", E_icode_o, 4'h1);
    chk("arst_dstE", E_dstE_o, 4'hF);
    chk("arst_cc", cc_obs, 3'b100);

    // Scoreboard
    foreach (exp_q[i]) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $error("FAIL %s: got %0h expected %0h", tag_q[i], obs_q[i], exp_q[i]);
      end
    end

    // Final report
    if (n_tests != exp_q.size()) begin
      n_fail++;
      $error("FAIL scoreboard: got %0d compared expected %0d", n_tests, exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    if (n_fail == 0)
      $display("PASS");
    else
      $display("FAIL");
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
